// File: rtl/frame_gen.sv
// Frame generator: 4 rows x 1041 cols (16 overhead, 1024 payload, 1 row-check), with far-end line replay.
// Define FRAME_GEN_ROW_PARITY_EN to make the row-check byte the XOR of the row payload; otherwise it is 0x00.
module frame_gen (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic [7:0]  i_pl_data,
    input  logic        i_pl_valid,
    output logic        o_pl_ready,
    input  logic        i_line_retrans_req,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic [1:0]  o_row_cnt,
    output logic [10:0] o_col_cnt
);
    localparam logic [10:0] LAST_OH_COL = 11'd15;
    localparam logic [10:0] LAST_PL_COL = 11'd1039;

    typedef enum logic [1:0] {IDLE, OH, PAYLOAD, CHK} state_t;

    state_t      state_q;
    logic        replay_q;
    logic        pending_q;
    logic [7:0]  mfas_q;
    logic [1:0]  row_q;
    logic [10:0] col_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic [1:0]  orow_q;
    logic [10:0] ocol_q;

    logic [7:0]  line_buf [1024];
    logic [9:0]  buf_addr;
    logic [7:0]  oh_byte;
    logic [7:0]  pl_byte;
    logic [7:0]  chk_byte;
    logic [7:0]  emit_byte;
    logic        pl_take;
    logic        emit;

    // col 16..1039 maps onto 0..1023 with 10-bit wraparound arithmetic
    assign buf_addr   = col_q[9:0] - 10'd16;
    assign o_pl_ready = (state_q == PAYLOAD) && !replay_q;
    assign pl_byte    = replay_q ? line_buf[buf_addr] : i_pl_data;
    assign pl_take    = (state_q == PAYLOAD) && (replay_q || i_pl_valid);
    assign emit       = (state_q == OH) || (state_q == CHK) || pl_take;

    always_comb begin
        oh_byte = 8'h00;
        if (row_q == 2'd0) begin
            if (col_q < 11'd3)       oh_byte = 8'hF6;
            else if (col_q < 11'd6)  oh_byte = 8'h28;
            else if (col_q == 11'd6) oh_byte = mfas_q;
        end
    end

    always_comb begin
        case (state_q)
            OH:      emit_byte = oh_byte;
            PAYLOAD: emit_byte = pl_byte;
            default: emit_byte = chk_byte;
        endcase
    end

`ifdef FRAME_GEN_ROW_PARITY_EN
    logic [7:0] par_q;
    assign chk_byte = par_q;

    // Replayed bytes come from the line buffer, so the replayed check byte matches the original.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                 par_q <= 8'h00;
        else if (state_q == CHK)   par_q <= 8'h00;
        else if (pl_take)          par_q <= par_q ^ pl_byte;
    end
`else
    assign chk_byte = 8'h00;
`endif

    always_ff @(posedge i_clk) begin
        if (o_pl_ready && i_pl_valid) line_buf[buf_addr] <= i_pl_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            replay_q  <= 1'b0;
            pending_q <= 1'b0;
            mfas_q    <= 8'h00;
            row_q     <= 2'd0;
            col_q     <= 11'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            orow_q    <= 2'd0;
            ocol_q    <= 11'd0;
        end else begin
            valid_q <= emit;
            if (emit) begin
                data_q <= emit_byte;
                orow_q <= row_q;
                ocol_q <= col_q;
            end
            if (state_q != IDLE && i_line_retrans_req) pending_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (i_enable) begin
                        state_q <= OH;
                        row_q   <= 2'd0;
                        col_q   <= 11'd0;
                    end
                end
                OH: begin
                    col_q <= col_q + 11'd1;
                    if (col_q == LAST_OH_COL) state_q <= PAYLOAD;
                end
                PAYLOAD: begin
                    if (pl_take) begin
                        col_q <= col_q + 11'd1;
                        if (col_q == LAST_PL_COL) state_q <= CHK;
                    end
                end
                CHK: begin
                    col_q <= 11'd0;
                    if (pending_q || i_line_retrans_req) begin
                        // resend the same row; row counter and MFAS stay put
                        pending_q <= 1'b0;
                        replay_q  <= 1'b1;
                        state_q   <= OH;
                    end else begin
                        replay_q <= 1'b0;
                        row_q    <= row_q + 2'd1;
                        if (row_q == 2'd3) begin
                            mfas_q  <= mfas_q + 8'd1;
                            state_q <= i_enable ? OH : IDLE;
                        end else begin
                            state_q <= OH;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_row_cnt = orow_q;
    assign o_col_cnt = ocol_q;
endmodule

// File: tb/tb_frame_gen.sv
// Bench for frame_gen: scenario table driving a stream-level frame model with a byte source and replay requests.
module tb_frame_gen;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_enable;
    logic [7:0]  i_pl_data;
    logic        i_pl_valid;
    logic        o_pl_ready;
    logic        i_line_retrans_req;
    logic [7:0]  o_data;
    logic        o_valid;
    logic [1:0]  o_row_cnt;
    logic [10:0] o_col_cnt;

    always #5 i_clk = ~i_clk;

    frame_gen dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_enable           (i_enable),
        .i_pl_data          (i_pl_data),
        .i_pl_valid         (i_pl_valid),
        .o_pl_ready         (o_pl_ready),
        .i_line_retrans_req (i_line_retrans_req),
        .o_data             (o_data),
        .o_valid            (o_valid),
        .o_row_cnt          (o_row_cnt),
        .o_col_cnt          (o_col_cnt)
    );

`ifdef FRAME_GEN_ROW_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int M_COL = 0, M_RAND = 1, M_CONST = 2, M_SINGLE = 3;

    typedef struct {
        int         mode;
        int         frames;
        int         gaps;
        int         stall;
        int         req_row;
        int         req_col;
        int         req_passes;
        int         rst_frame;
        int         chk_known;
        logic [7:0] chk_par;
        int         min_run;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] src_rand [8192];
    vec_t       cur;
    int         target;

    int         m_row, m_col, m_frame, m_k;
    bit         m_replay, m_req, m_done;
    logic [7:0] m_mfas;
    logic [7:0] m_buf [1024];
    int         extra_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (row=%0d col=%0d)", name, act, exp, m_row, m_col);
        end
    endtask

    // k-th payload byte offered by the upstream source
    function automatic logic [7:0] src_byte(input int mode, input int k);
        int v;
        case (mode)
            M_COL:   v = (16 + k % 1024) % 256;
            M_RAND:  v = int'(src_rand[k % 8192]);
            M_CONST: v = 'h5A;
            default: v = (k % 1024 == 0) ? 1 : 0;
        endcase
        return v[7:0];
    endfunction

    task automatic model_init();
        m_row = 0; m_col = 0; m_frame = 0; m_k = 0;
        m_replay = 0; m_req = 0; m_done = 0; m_mfas = 8'h00;
    endtask

    task automatic model_step();
        logic [7:0] exp_b;
        exp_b = 8'h00;
        if (m_col < 16) begin
            if (m_row == 0) begin
                if (m_col < 3)       exp_b = 8'hF6;
                else if (m_col < 6)  exp_b = 8'h28;
                else if (m_col == 6) exp_b = m_mfas;
            end
        end else if (m_col < 1040) begin
            if (m_replay) exp_b = m_buf[m_col-16];
            else begin
                exp_b = src_byte(cur.mode, m_k);
                m_k++;
                m_buf[m_col-16] = exp_b;
            end
        end else begin
            if (PAR_EN) for (int i = 0; i < 1024; i++) exp_b ^= m_buf[i];
            if (cur.chk_known != 0 && m_row == 0 && m_frame == 0 && !m_replay)
                check("chk_table", {24'h0, o_data}, {24'h0, (PAR_EN ? cur.chk_par : 8'h00)});
        end
        check("stream", {11'h0, o_row_cnt, o_col_cnt, o_data}, {11'h0, m_row[1:0], m_col[10:0], exp_b});

        if (m_col == 0 && m_row == 0 && !m_replay && m_frame == target - 1) i_enable = 1'b0;
        if (m_col == 1040) begin
            m_col = 0;
            if (m_req) begin
                m_replay = 1; m_req = 0;
            end else begin
                m_replay = 0;
                if (m_row == 3) begin
                    m_row = 0; m_mfas++; m_frame++;
                    if (m_frame == target) m_done = 1;
                end else m_row++;
            end
        end else m_col++;
    endtask

    task automatic run_vec(input vec_t v);
        int cyc = 0, first_lat = 0, run = 0, max_run = 0;
        int stall_left = 0, stall_obs = 0, req_stage = 0, passes_seen = 0;
        int ready_hi = 0, idle_cnt = 0, s_k = 0;
        bit stall_done = 0, stall_active = 0, req_fire, acc_pending, rst_done = 0, rst_now;
        cur = v; target = v.frames; extra_valid = 0;

        i_rst = 1; i_enable = 0; i_pl_valid = 0; i_pl_data = 0; i_line_retrans_req = 0;
        @(posedge i_clk); #1;
        check("reset_outputs", {9'h0, o_data, o_valid, o_pl_ready, o_row_cnt, o_col_cnt}, 32'h0);
        model_init();
        i_rst = 0; i_enable = 1; i_pl_valid = 1; i_pl_data = src_byte(v.mode, 0);
        acc_pending = i_pl_valid && o_pl_ready;

        while (cyc < 20000 && idle_cnt < 20) begin
            @(posedge i_clk); #1; cyc++;
            if (acc_pending) s_k++;
            req_fire = 0; rst_now = 0;
            if (o_valid && first_lat == 0) first_lat = cyc;
            if (o_valid) begin run++; if (run > max_run) max_run = run; end else run = 0;
            if (stall_active && !o_valid && o_col_cnt == 11'd99) stall_obs++;
            if (o_valid) stall_active = 0;

            if (o_valid && m_done) extra_valid++;
            else if (o_valid) begin
                if (m_replay && o_col_cnt >= 16 && o_col_cnt <= 1038 && o_pl_ready) ready_hi++;
                if (v.stall != 0 && !stall_done && m_frame == 0 && o_row_cnt == 0 && o_col_cnt == 11'd99) begin
                    stall_done = 1; stall_left = 5; stall_active = 1;
                end
                if (v.req_row >= 0 && m_frame == 0 && o_row_cnt == v.req_row) begin
                    if (req_stage == 0 && !m_replay && o_col_cnt == v.req_col - 1) begin
                        req_fire = 1; m_req = 1; req_stage = 1;
                    end else if (req_stage == 1 && v.req_passes == 2 && m_replay && o_col_cnt == 11'd1039) begin
                        req_fire = 1; m_req = 1; req_stage = 2;
                    end
                    if (o_col_cnt == 11'd1040) passes_seen++;
                end
                if (v.rst_frame >= 0 && !rst_done && m_frame == v.rst_frame && o_row_cnt == 2 && o_col_cnt == 11'd300)
                    rst_now = 1;
                model_step();
            end
            if (m_done) idle_cnt++;

            if (rst_now) begin
                i_rst = 1; #1;
                check("midframe_reset", {9'h0, o_data, o_valid, o_pl_ready, o_row_cnt, o_col_cnt}, 32'h0);
                @(posedge i_clk); #1; cyc++;
                i_rst = 0; i_enable = 1;
                model_init(); target = 1; s_k = 0; run = 0; rst_done = 1;
            end

            i_line_retrans_req = req_fire;
            if (stall_left > 0) begin i_pl_valid = 0; stall_left--; end
            else i_pl_valid = (v.gaps != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            i_pl_data = src_byte(v.mode, s_k);
            acc_pending = i_pl_valid && o_pl_ready;
        end

        check("done_in_budget", {31'h0, m_done}, 32'h1);
        check("start_latency", first_lat, 2);
        check("no_output_after_end", extra_valid, 0);
        check("bytes_taken_vs_sent", s_k, m_k);
        if (v.min_run > 0) check("continuous_valid", {31'h0, max_run >= v.min_run}, 32'h1);
        if (v.stall != 0) check("stall_cycles_col99", stall_obs, 5);
        if (v.req_row >= 0) begin
            check("row_send_count", passes_seen, 1 + v.req_passes);
            check("ready_low_in_replay", ready_hi, 0);
        end
        if (v.rst_frame >= 0) check("midframe_reset_hit", {31'h0, rst_done}, 32'h1);
    endtask

    initial begin
        vec_t vecs[7];
        for (int i = 0; i < 8192; i++) src_rand[i] = 8'($urandom);
        //          mode      frm gap stl rrow rcol  pas rstf known par    minrun
        vecs[0] = '{M_COL,    2,  0,  0,  -1,  0,    0,  -1,  1,    8'h00, 4164};
        vecs[1] = '{M_COL,    1,  0,  1,   1,  500,  1,  -1,  1,    8'h00, 0};
        vecs[2] = '{M_RAND,   1,  1,  0,   1,  500,  2,  -1,  0,    8'h00, 0};
        vecs[3] = '{M_CONST,  1,  0,  0,  -1,  0,    0,  -1,  1,    8'h00, 0};
        vecs[4] = '{M_SINGLE, 1,  0,  0,  -1,  0,    0,  -1,  1,    8'h01, 0};
        vecs[5] = '{M_RAND,   1,  1,  0,  int'($urandom_range(0, 3)), int'($urandom_range(1, 1040)),
                    1, -1, 0, 8'h00, 0};
        vecs[6] = '{M_COL,    2,  0,  0,  -1,  0,    0,   1,  1,    8'h00, 0};
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
